// File: rtl/ifm_rx_ingress.sv
// ---------------------------------------------------------------------------
// ifm_rx_ingress
//
// Receive-side ingress stage between a MAC AXI-Stream master and a pair of
// FIFOs: a data FIFO holding {last, keep, data} words and an info FIFO
// holding one 24-bit descriptor per accepted frame. The MAC is never
// backpressured. A frame that starts while either FIFO is short of space is
// dropped in full. A frame longer than C_MAX_LEN bytes is cut at the limit
// and its remaining beats are discarded.
//
// Descriptor layout: [15:0] byte length, [16] MAC error flag (tuser of the
// last beat, 0 when cut), [17] oversize, [23:18] zero.
//
// Optional feature: define IFM_STATS_EN to build the four 32-bit statistics
// counters. Without it the stat_* ports are present and tied to zero.
//
// Ports
//   rx_clk               clock
//   sys_rst_n            synchronous reset, active low
//   rx_axis_mac_t*       MAC receive stream (tdata/tkeep/tlast/tuser/tvalid)
//   rx_axis_mac_tready   constant 1
//   data_fifo_wdata/wren data FIFO write port, data_fifo_afull almost full
//   info_fifo_wdata/wren info FIFO write port, info_fifo_wfull full
//   stats_clr            synchronous clear of the statistics counters
//   stat_*_cnt           accepted / dropped / errored / oversize frame counts
//   ifm_in_fsm_dbg       {2'b0, state}
// ---------------------------------------------------------------------------
module ifm_rx_ingress #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_KEEP_WIDTH = C_DATA_WIDTH / 8,
  parameter int C_MAX_LEN    = 9600
) (
  input  logic                                rx_clk,
  input  logic                                sys_rst_n,
  input  logic [C_DATA_WIDTH-1:0]             rx_axis_mac_tdata,
  input  logic [C_KEEP_WIDTH-1:0]             rx_axis_mac_tkeep,
  input  logic                                rx_axis_mac_tlast,
  input  logic                                rx_axis_mac_tuser,
  input  logic                                rx_axis_mac_tvalid,
  output logic                                rx_axis_mac_tready,
  output logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]  data_fifo_wdata,
  output logic                                data_fifo_wren,
  input  logic                                data_fifo_afull,
  output logic [23:0]                         info_fifo_wdata,
  output logic                                info_fifo_wren,
  input  logic                                info_fifo_wfull,
  input  logic                                stats_clr,
  output logic [31:0]                         stat_frame_cnt,
  output logic [31:0]                         stat_drop_cnt,
  output logic [31:0]                         stat_err_cnt,
  output logic [31:0]                         stat_ovs_cnt,
  output logic [3:0]                          ifm_in_fsm_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_DROP  = 2'd2,
    S_TRUNC = 2'd3
  } state_t;

  // Number of valid bytes in a beat, widened so the running sum cannot wrap.
  function automatic logic [16:0] popcount_f(input logic [C_KEEP_WIDTH-1:0] keep);
    logic [16:0] cnt;
    cnt = 17'd0;
    for (int i = 0; i < C_KEEP_WIDTH; i++) begin
      cnt = cnt + {16'd0, keep[i]};
    end
    return cnt;
  endfunction

  state_t                             state_r;
  logic [15:0]                        len_r;
  logic                               data_wren_r;
  logic [C_DATA_WIDTH+C_KEEP_WIDTH:0] data_wdata_r;
  logic                               info_wren_r;
  logic [23:0]                        info_wdata_r;

  logic [16:0] len_next_s;
  logic        over_s;
  logic        start_ok_s;
  logic        write_s;
  logic        wlast_s;
  logic        ovs_s;
  logic        drop_s;

  assign rx_axis_mac_tready = 1'b1;
  assign data_fifo_wren     = data_wren_r;
  assign data_fifo_wdata    = data_wdata_r;
  assign info_fifo_wren     = info_wren_r;
  assign info_fifo_wdata    = info_wdata_r;
  assign ifm_in_fsm_dbg     = {2'b00, state_r};

  // Beat decode: length bookkeeping and which write (if any) this beat makes.
  always_comb begin
    len_next_s = {1'b0, len_r} + popcount_f(rx_axis_mac_tkeep);
    // A frame that has already filled C_MAX_LEN and still continues can only
    // grow beyond it, so it is cut on this beat rather than one beat later.
    over_s     = (len_next_s > 17'(C_MAX_LEN)) ||
                 ((len_next_s == 17'(C_MAX_LEN)) && !rx_axis_mac_tlast);
    start_ok_s = !(data_fifo_afull || info_fifo_wfull);
    write_s    = 1'b0;
    wlast_s    = 1'b0;
    ovs_s      = 1'b0;
    drop_s     = 1'b0;
    if (rx_axis_mac_tvalid) begin
      case (state_r)
        S_IDLE: begin
          if (!start_ok_s) begin
            drop_s = 1'b1;
          end else begin
            write_s = 1'b1;
            ovs_s   = over_s;
            wlast_s = over_s || rx_axis_mac_tlast;
          end
        end
        S_PASS: begin
          write_s = 1'b1;
          ovs_s   = over_s;
          wlast_s = over_s || rx_axis_mac_tlast;
        end
        default: begin
          write_s = 1'b0;
        end
      endcase
    end else begin
      write_s = 1'b0;
    end
  end

  // Frame FSM together with the registered FIFO write ports and length counter.
  always_ff @(posedge rx_clk) begin
    if (!sys_rst_n) begin
      state_r      <= S_IDLE;
      len_r        <= 16'd0;
      data_wren_r  <= 1'b0;
      data_wdata_r <= '0;
      info_wren_r  <= 1'b0;
      info_wdata_r <= 24'd0;
    end else begin
      data_wren_r <= write_s;
      info_wren_r <= wlast_s;
      if (write_s) begin
        data_wdata_r <= {wlast_s, rx_axis_mac_tkeep, rx_axis_mac_tdata};
      end
      if (wlast_s) begin
        info_wdata_r <= {6'd0, ovs_s, rx_axis_mac_tuser & ~ovs_s, len_next_s[15:0]};
        len_r        <= 16'd0;
      end else if (write_s) begin
        len_r <= len_next_s[15:0];
      end

      case (state_r)
        S_IDLE: begin
          if (rx_axis_mac_tvalid && !rx_axis_mac_tlast) begin
            if (drop_s) begin
              state_r <= S_DROP;
            end else if (ovs_s) begin
              state_r <= S_TRUNC;
            end else begin
              state_r <= S_PASS;
            end
          end
        end
        S_PASS: begin
          if (rx_axis_mac_tvalid) begin
            if (rx_axis_mac_tlast) begin
              state_r <= S_IDLE;
            end else if (ovs_s) begin
              state_r <= S_TRUNC;
            end
          end
        end
        S_DROP, S_TRUNC: begin
          if (rx_axis_mac_tvalid && rx_axis_mac_tlast) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef IFM_STATS_EN
  logic [31:0] frame_cnt_r;
  logic [31:0] drop_cnt_r;
  logic [31:0] err_cnt_r;
  logic [31:0] ovs_cnt_r;

  // Statistics counters; a clear takes priority over a same-cycle event.
  always_ff @(posedge rx_clk) begin
    if (!sys_rst_n || stats_clr) begin
      frame_cnt_r <= 32'd0;
      drop_cnt_r  <= 32'd0;
      err_cnt_r   <= 32'd0;
      ovs_cnt_r   <= 32'd0;
    end else begin
      if (wlast_s) begin
        frame_cnt_r <= frame_cnt_r + 32'd1;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
      if (wlast_s && rx_axis_mac_tuser && !ovs_s) begin
        err_cnt_r <= err_cnt_r + 32'd1;
      end
      if (ovs_s) begin
        ovs_cnt_r <= ovs_cnt_r + 32'd1;
      end
    end
  end

  assign stat_frame_cnt = frame_cnt_r;
  assign stat_drop_cnt  = drop_cnt_r;
  assign stat_err_cnt   = err_cnt_r;
  assign stat_ovs_cnt   = ovs_cnt_r;
`else
  logic unused_stats_clr_s;
  assign unused_stats_clr_s = stats_clr;
  assign stat_frame_cnt     = 32'd0;
  assign stat_drop_cnt      = 32'd0;
  assign stat_err_cnt       = 32'd0;
  assign stat_ovs_cnt       = 32'd0;
`endif

endmodule
